// File: rtl/lane_sum_sequencer.sv
// lane_sum_sequencer: steps the mux select through every lane and accumulates the returned values.
// Define LANE_PIPE_REG_EN to register mux_in, which adds a DRAIN state and one cycle of latency.
module lane_sum_sequencer #(
    parameter int DATA_W    = 2,
    parameter int NUM_LANES = 6,
    parameter int SEL_W     = 3,
    parameter int ACC_W     = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stall,
    input  logic [DATA_W-1:0] mux_in,
    output logic [SEL_W-1:0]  sel,
    output logic [ACC_W-1:0]  sum,
    output logic              done,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
`ifdef LANE_PIPE_REG_EN
    localparam state_t SCAN_EXIT = DRAIN;
`else
    localparam state_t SCAN_EXIT = DONE;
`endif
    state_t state, state_d;
    logic [SEL_W-1:0] cnt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic last, step;
    assign last = cnt == SEL_W'(NUM_LANES - 1);
    assign step = state == SCAN && !stall;
    assign sel  = state == SCAN ? cnt : '0;
    assign done = state == DONE;
    assign busy = state == SCAN || state == DRAIN;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = step && last ? SCAN_EXIT : SCAN;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_d;
    end
`ifdef LANE_PIPE_REG_EN
    // The tag marks a lane that was actually selected; stalled cycles leave no tag.
    logic [DATA_W-1:0] pipe_val;
    logic pipe_vld;
    assign acc_nxt = acc + ACC_W'(pipe_val);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pipe_val <= '0;
            pipe_vld <= 1'b0;
        end else begin
            pipe_val <= mux_in;
            pipe_vld <= step;
        end
    end
`else
    assign acc_nxt = acc + ACC_W'(mux_in);
`endif
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
            acc <= '0;
            sum <= '0;
        end else if (state == IDLE && start) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            if (step && !last) cnt <= cnt + SEL_W'(1);
`ifdef LANE_PIPE_REG_EN
            if (pipe_vld) acc <= acc_nxt;
            if (state == DRAIN) sum <= acc_nxt;
`else
            if (step) acc <= acc_nxt;
            if (step && last) sum <= acc_nxt;
`endif
        end
    end
endmodule

// File: doc/lane_sum_sequencer.md
Name: lane_sum_sequencer

Overview:
- Sequential stage wrapped around the 6:1 lane multiplexer in the adder path of the convolution accelerator.
- Upstream role: drives the mux select through lanes 0..5, one lane per cycle.
- Downstream role: consumes the selected 2-bit partial product each cycle and accumulates it.
- After all six lanes are summed, presents the total to the next adder stage with a one-cycle done strobe.

Parameters:
- DATA_W, 2: width of the lane value returned by the mux.
- NUM_LANES, 6: number of lanes scanned per operation. Valid range 1..2^SEL_W.
- SEL_W, 3: width of the select output.
- ACC_W, 5: accumulator and sum width. Must be at least ceil(log2(NUM_LANES*(2^DATA_W-1)+1)); the default gives max 18, which fits in 5 bits.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a scan. Honoured only in IDLE.
- stall  in  1  freezes the scan (sel, lane counter, accumulator) while high in SCAN.
- mux_in  in  DATA_W  selected lane value returned by the mux for the current sel.
- sel  out  SEL_W  lane select driven to the mux.
- sum  out  ACC_W  result of the last completed scan. Held until the next completion.
- done  out  1  one-cycle pulse when sum updates.
- busy  out  1  high from the cycle after start is accepted until done.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE, sel=0, acc=0, sum=0, done=0, busy=0. Asserting reset mid-scan aborts the scan; no done is issued.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - sel=0, busy=0.
  - On start=1: acc<=0, lane counter<=0, next state SCAN.
- SCAN:
  - busy=1 and sel=lane counter. mux_in is combinational from sel and is sampled in the same cycle.
  - If stall=0: acc<=acc+zero-extended mux_in, lane counter and sel increment.
    - When the lane being added is NUM_LANES-1, go to DONE instead of incrementing.
  - If stall=1: sel, counter and acc hold.
- DONE:
  - sum<=acc (the final add already committed), done=1 for exactly one cycle, busy=0.
  - Next state IDLE; sel returns to 0.
- Timing: start accepted at cycle T, lanes sampled T+1..T+6, done high at T+7 with sum valid in the same cycle. Each stalled cycle adds one cycle.
- start is ignored in SCAN and DONE; there is no queueing. start in the DONE cycle is also ignored, so back-to-back scans are 8 cycles apart minimum.
- Arithmetic is unsigned; the add wraps modulo 2^ACC_W. No wrap occurs with legal parameters.
- sel never exceeds NUM_LANES-1, so mux selects 6 and 7 (default output 0) are never driven.

Optional Feature:
- Macro: LANE_PIPE_REG_EN.
- Defined:
  - mux_in is captured into a register together with a valid tag = (state==SCAN && stall==0). Accumulation uses the registered value when the tag is set.
  - An extra DRAIN state follows the last select so the final lane can be added.
  - done moves to T+8. stall still freezes sel, and a stalled cycle produces no tag.
- Undefined: no input register; timing exactly as in Behaviour.

Test Plan:
- Lanes z0..z5 = 3,2,1,0,3,3; start pulse at T, stall=0 -> sel steps 0..5 over T+1..T+6; done=1 only at T+7; sum=12; busy low at T+7.
- All lanes = 3 -> sum=18 (5'b10010), no wrap. All lanes = 0 -> sum=0 and done still pulses.
- Lanes 1,1,1,1,1,1 with stall high for 2 cycles while sel=3 -> sel holds at 3 for 2 cycles; done at T+9; sum=6.
- Re-pulse start at T+3 and again at T+7 -> no effect on the running scan; the next scan starts only on a start pulse at T+8 or later.
- Drive RST low at T+4 -> sel=0, sum=0, busy=0 immediately, asynchronously. No done is issued; a new start after release gives a correct sum.
- With LANE_PIPE_REG_EN defined, the lanes 3,2,1,0,3,3 case -> done at T+8, sum=12.
